hht_fetch_sched: RTL and testbench
==================================

HHT_FETCH_SCHED -- requirements
Module: hht_fetch_sched

Interface
REQ-001 SHALL have parameter V_SIZE, default 9, number of filter coefficients loaded per run.
REQ-002 SHALL have parameter DW, default 32, data and address width.
REQ-003 SHALL have a single clock; reset is asynchronous and active-high (ports named Clk and Rst, as the codebase does).
REQ-004 Clk  in  1  rising-edge clock.
REQ-005 Rst  in  1  asynchronous active-high reset.
REQ-006 start  in  1  one-cycle run request; honoured only in IDLE.
REQ-007 abort  in  1  synchronous run cancel.
REQ-008 v_values_base  in  DW  coefficient base address, sampled on accepted start.
REQ-009 wdata_col_base  in  DW  column base address, sampled on accepted start.
REQ-010 csize  in  DW  column sample count, sampled on accepted start.
REQ-011 addr2 / dataIn2  out / in  DW  coefficient memory port; combinational read, data valid in the same cycle as the address.
REQ-012 addr1 / dataIn1  out / in  DW  column memory port; combinational read, data valid in the same cycle as the address.
REQ-013 coef  out  V_SIZE*DW  coefficient bank, coef[k] at bits [k*DW +: DW].
REQ-014 coef_valid  out  1  bank holds a complete set for the current run.
REQ-015 s_valid / s_ready / s_data[DW] / s_last  out / in / out / out  sample stream to datapath.
REQ-016 busy / done / err  out  1 each  run active / one-cycle completion pulse / zero-length run.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD_V, STREAM, DONE.
REQ-018 IDLE: start=1 with csize!=0 SHALL latch the three inputs, clear coef_valid, set addr2=v_values_base and go to LOAD_V.
REQ-019 IDLE: start=1 with csize==0 SHALL go to DONE with err=1 and leave coef and coef_valid unchanged.
REQ-020 LOAD_V: each edge SHALL capture dataIn2 into coef[k] and advance addr2 to base+k+1, for k=0..V_SIZE-1, so the phase takes exactly V_SIZE cycles.
REQ-021 On capture of coef[V_SIZE-1], the block SHALL set coef_valid=1, set addr1=wdata_col_base and enter STREAM.
REQ-022 STREAM: s_valid SHALL be 1 and s_data SHALL equal dataIn1 combinationally.
REQ-023 A transfer occurs on s_valid&&s_ready; on a transfer, addr1 SHALL increment by 1.
REQ-024 While s_ready=0, addr1, s_data and s_last SHALL hold.
REQ-025 s_last SHALL be 1 while the sample index equals csize-1; the transfer with s_last SHALL move the FSM to DONE.
REQ-026 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-027 busy SHALL be 1 in LOAD_V and STREAM only.
REQ-028 addr1 SHALL be 0 outside STREAM, and addr2 SHALL be 0 outside LOAD_V.
REQ-029 Address arithmetic SHALL wrap modulo 2^DW, and the sample counter SHALL be DW bits wide.
REQ-030 start SHALL be ignored outside IDLE.
REQ-031 abort in LOAD_V or STREAM SHALL return the FSM to IDLE on the next edge with done=0, coef_valid=0 and addresses=0; abort SHALL take priority over a simultaneous transfer.
REQ-032 coef and coef_valid SHALL persist in IDLE until the next accepted start or abort.

Reset
REQ-033 Rst=1 SHALL immediately, independent of Clk, set state=IDLE, all counters, addresses, coef, coef_valid, s_valid, s_last, busy, done and err to 0.
REQ-034 A reset asserted mid-run SHALL discard the run, with no done pulse after release.

Verification
REQ-035 v_values_base=2, wdata_col_base=340, csize=307, s_ready=1, memory as in the HHT bench -> coef={95,56,36,48,44,99,16,36,4} after 9 LOAD_V cycles; first s_data=24, second 10; last s_data=11 at addr1=646 with s_last=1; done pulses once; total start-to-done = 1+9+307 cycles.
REQ-036 Same run with s_ready toggled 0/1 every cycle -> 307 transfers, no duplicates or skips, addr1 and s_data stable while s_ready=0.
REQ-037 csize=0 -> err=1 and done=1 in the cycle after start, no memory addresses driven, busy never set.
REQ-038 csize=1 -> single transfer carrying s_last=1, then done.
REQ-039 abort at sample 50, then a new start -> no done pulse for the aborted run; the restart refetches coefficients from addr2=2.
REQ-040 Rst pulsed mid-STREAM -> all outputs 0 asynchronously; start after release runs normally.

Source files
------------

// File: rtl/hht_fetch_sched.sv
// Coefficient/column fetch scheduler: loads V_SIZE coefficients into a bank,
// then streams csize column samples to the datapath with valid/ready handshake.
module hht_fetch_sched #(
  parameter int V_SIZE = 9,
  parameter int DW     = 32
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [DW-1:0]        v_values_base,
  input  logic [DW-1:0]        wdata_col_base,
  input  logic [DW-1:0]        csize,
  output logic [DW-1:0]        addr2,
  input  logic [DW-1:0]        dataIn2,
  output logic [DW-1:0]        addr1,
  input  logic [DW-1:0]        dataIn1,
  output logic [V_SIZE*DW-1:0] coef,
  output logic                 coef_valid,
  output logic                 s_valid,
  input  logic                 s_ready,
  output logic [DW-1:0]        s_data,
  output logic                 s_last,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int KW = (V_SIZE > 1) ? $clog2(V_SIZE) : 1;

  typedef enum logic [1:0] {IDLE, LOAD_V, STREAM, DONE} state_t;

  state_t              r_state, w_next;
  logic [KW-1:0]       r_k;
  logic [DW-1:0]       r_idx;
  logic [DW-1:0]       r_csize;
  logic [DW-1:0]       r_cbase;
  logic [DW-1:0]       r_addr1;
  logic [DW-1:0]       r_addr2;
  logic [V_SIZE*DW-1:0] r_coef;
  logic                r_coef_valid;
  logic                r_err;
  logic                w_k_last;
  logic                w_last;

  assign w_k_last = (r_k == KW'(V_SIZE - 1));
  assign w_last   = (r_idx == r_csize - 1'b1);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   if (start) w_next = (csize == '0) ? DONE : LOAD_V;
      LOAD_V: if (abort) w_next = IDLE;
              else if (w_k_last) w_next = STREAM;
      STREAM: if (abort) w_next = IDLE;
              else if (s_ready && w_last) w_next = DONE;
      DONE:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_k          <= '0;
      r_idx        <= '0;
      r_csize      <= '0;
      r_cbase      <= '0;
      r_addr1      <= '0;
      r_addr2      <= '0;
      r_coef       <= '0;
      r_coef_valid <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            if (csize != '0) begin
              r_csize      <= csize;
              r_cbase      <= wdata_col_base;
              r_addr2      <= v_values_base;
              r_k          <= '0;
              r_idx        <= '0;
              r_coef_valid <= 1'b0;
              r_err        <= 1'b0;
            end else begin
              r_err        <= 1'b1;
            end
          end
        end
        LOAD_V: begin
          if (abort) begin
            r_coef_valid <= 1'b0;
            r_addr2      <= '0;
          end else begin
            for (int unsigned k = 0; k < V_SIZE; k++)
              if (r_k == KW'(k)) r_coef[k*DW +: DW] <= dataIn2;
            if (w_k_last) begin
              r_coef_valid <= 1'b1;
              r_addr2      <= '0;
              r_addr1      <= r_cbase;
            end else begin
              r_addr2 <= r_addr2 + 1'b1;
              r_k     <= r_k + 1'b1;
            end
          end
        end
        STREAM: begin
          // abort wins over a transfer presented in the same cycle
          if (abort) begin
            r_coef_valid <= 1'b0;
            r_addr1      <= '0;
          end else if (s_ready) begin
            r_idx   <= r_idx + 1'b1;
            r_addr1 <= w_last ? '0 : r_addr1 + 1'b1;
          end
        end
        DONE:    r_err <= 1'b0;
        default: ;
      endcase
    end
  end

  assign addr1      = r_addr1;
  assign addr2      = r_addr2;
  assign coef       = r_coef;
  assign coef_valid = r_coef_valid;
  assign s_valid    = (r_state == STREAM);
  assign s_data     = s_valid ? dataIn1 : '0;
  assign s_last     = s_valid && w_last;
  assign busy       = (r_state == LOAD_V) || (r_state == STREAM);
  assign done       = (r_state == DONE);
  assign err        = (r_state == DONE) && r_err;

endmodule

// File: tb/tb_hht_fetch_sched.sv
// Directed bench for hht_fetch_sched with combinational memory models.
module tb_hht_fetch_sched;

  localparam int V_SIZE = 9;
  localparam int DW     = 32;

  logic                 Clk = 1'b0;
  logic                 Rst, start, abort, s_ready;
  logic [DW-1:0]        v_values_base, wdata_col_base, csize;
  logic [DW-1:0]        addr1, addr2, dataIn1, dataIn2, s_data;
  logic [V_SIZE*DW-1:0] coef;
  logic                 coef_valid, s_valid, s_last, busy, done, err;

  int checks = 0;
  int errors = 0;
  int exp_coef[V_SIZE] = '{95, 56, 36, 48, 44, 99, 16, 36, 4};

  hht_fetch_sched #(.V_SIZE(V_SIZE), .DW(DW)) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .abort(abort),
    .v_values_base(v_values_base), .wdata_col_base(wdata_col_base), .csize(csize),
    .addr2(addr2), .dataIn2(dataIn2), .addr1(addr1), .dataIn1(dataIn1),
    .coef(coef), .coef_valid(coef_valid), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .busy(busy), .done(done), .err(err)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] coef_mem(input logic [31:0] a);
    case (a)
      32'd2:  return 32'd95;
      32'd3:  return 32'd56;
      32'd4:  return 32'd36;
      32'd5:  return 32'd48;
      32'd6:  return 32'd44;
      32'd7:  return 32'd99;
      32'd8:  return 32'd16;
      32'd9:  return 32'd36;
      32'd10: return 32'd4;
      default: return a * 32'd3 + 32'd1000;
    endcase
  endfunction

  function automatic logic [31:0] col_mem(input logic [31:0] a);
    case (a)
      32'd340: return 32'd24;
      32'd341: return 32'd10;
      32'd646: return 32'd11;
      default: return (a * 32'd7 + 32'd3) & 32'hFF;
    endcase
  endfunction

  always_comb dataIn2 = coef_mem(addr2);
  always_comb dataIn1 = col_mem(addr1);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic launch(input logic [31:0] vb, input logic [31:0] cb, input logic [31:0] n);
    v_values_base  = vb;
    wdata_col_base = cb;
    csize          = n;
    start          = 1'b1;
    tick();
    start          = 1'b0;
  endtask

  // Full 307-sample run; optional s_ready toggling every cycle.
  task automatic full_run(input bit toggle);
    int t, xfers, bad, last_seen;
    logic [31:0] last_data, last_addr;
    launch(32'd2, 32'd340, 32'd307);
    t = 1;
    chk("ld_addr2_first", addr2, 32'd2);
    chk("ld_busy", {31'd0, busy}, 32'd1);
    chk("ld_coef_valid_clr", {31'd0, coef_valid}, 32'd0);
    for (int i = 0; i < V_SIZE; i++) begin
      tick();
      t++;
    end
    chk("st_s_valid", {31'd0, s_valid}, 32'd1);
    chk("st_coef_valid", {31'd0, coef_valid}, 32'd1);
    chk("st_addr1_base", addr1, 32'd340);
    chk("st_addr2_zero", addr2, 32'd0);
    chk("st_first_data", s_data, 32'd24);
    for (int k = 0; k < V_SIZE; k++)
      chk($sformatf("coef%0d", k), coef[k*DW +: DW], exp_coef[k]);
    xfers = 0; bad = 0; last_seen = 0; last_data = '0; last_addr = '0;
    s_ready = toggle ? 1'b0 : 1'b1;
    while (!done && t < 2000) begin
      if (!s_valid || addr1 != 32'd340 + xfers || s_data != col_mem(32'd340 + xfers) ||
          s_last != (xfers == 306)) bad++;
      if (s_last) begin
        last_seen++;
        last_data = s_data;
        last_addr = addr1;
      end
      if (xfers == 1 && !toggle && s_data != 32'd10) bad++;
      if (s_ready) xfers++;
      tick();
      t++;
      if (toggle) s_ready = ~s_ready;
    end
    s_ready = 1'b1;
    chk("run_done", {31'd0, done}, 32'd1);
    chk("run_err", {31'd0, err}, 32'd0);
    chk("run_xfers", xfers, 32'd307);
    chk("run_sample_errs", bad, 32'd0);
    chk("run_last_data", last_data, 32'd11);
    chk("run_last_addr", last_addr, 32'd646);
    if (!toggle) chk("run_cycles", t, 32'd317);
    tick();
    chk("post_done_clear", {31'd0, done}, 32'd0);
    chk("post_busy", {31'd0, busy}, 32'd0);
    chk("post_coef_valid_keep", {31'd0, coef_valid}, 32'd1);
    chk("post_addr1", addr1, 32'd0);
  endtask

  initial begin
    Rst = 1'b1; start = 1'b0; abort = 1'b0; s_ready = 1'b1;
    v_values_base = '0; wdata_col_base = '0; csize = '0;
    tick(); tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_s_valid", {31'd0, s_valid}, 32'd0);
    chk("rst_addr1", addr1, 32'd0);
    chk("rst_addr2", addr2, 32'd0);
    chk("rst_coef_valid", {31'd0, coef_valid}, 32'd0);
    chk("rst_coef0", coef[31:0], 32'd0);
    Rst = 1'b0;
    tick();

    full_run(1'b0);
    full_run(1'b1);

    // zero-length run
    launch(32'd2, 32'd340, 32'd0);
    chk("z_done", {31'd0, done}, 32'd1);
    chk("z_err", {31'd0, err}, 32'd1);
    chk("z_busy", {31'd0, busy}, 32'd0);
    chk("z_addr1", addr1, 32'd0);
    chk("z_addr2", addr2, 32'd0);
    chk("z_coef_valid_keep", {31'd0, coef_valid}, 32'd1);
    chk("z_coef0_keep", coef[31:0], 32'd95);
    tick();
    chk("z_done_clear", {31'd0, done}, 32'd0);
    chk("z_err_clear", {31'd0, err}, 32'd0);

    // single-sample run
    launch(32'd2, 32'd100, 32'd1);
    for (int i = 0; i < V_SIZE; i++) tick();
    chk("one_s_valid", {31'd0, s_valid}, 32'd1);
    chk("one_s_last", {31'd0, s_last}, 32'd1);
    chk("one_addr1", addr1, 32'd100);
    chk("one_s_data", s_data, 32'd703 & 32'hFF);
    tick();
    chk("one_done", {31'd0, done}, 32'd1);
    chk("one_err", {31'd0, err}, 32'd0);
    tick();

    // stall holds state
    launch(32'd2, 32'd340, 32'd307);
    for (int i = 0; i < V_SIZE; i++) tick();
    s_ready = 1'b0;
    tick(); tick();
    chk("stall_addr1", addr1, 32'd340);
    chk("stall_data", s_data, 32'd24);
    s_ready = 1'b1;
    // start ignored while busy
    start = 1'b1; csize = 32'd0;
    tick();
    start = 1'b0;
    chk("busy_start_ignored", addr1, 32'd341);
    for (int i = 0; i < 49; i++) tick();
    chk("abort_at50_addr1", addr1, 32'd390);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_coef_valid", {31'd0, coef_valid}, 32'd0);
    chk("abort_addr1", addr1, 32'd0);
    tick();
    chk("abort_no_done", {31'd0, done}, 32'd0);

    // restart refetches coefficients
    launch(32'd2, 32'd340, 32'd307);
    chk("restart_addr2", addr2, 32'd2);
    tick();
    chk("restart_addr2_next", addr2, 32'd3);
    for (int i = 0; i < V_SIZE + 19; i++) tick();
    chk("pre_rst_streaming", {31'd0, s_valid}, 32'd1);

    // asynchronous reset mid-stream
    #2 Rst = 1'b1;
    #1;
    chk("arst_s_valid", {31'd0, s_valid}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_addr1", addr1, 32'd0);
    chk("arst_s_data", s_data, 32'd0);
    chk("arst_coef_valid", {31'd0, coef_valid}, 32'd0);
    chk("arst_coef0", coef[31:0], 32'd0);
    tick();
    Rst = 1'b0;
    tick(); tick();
    chk("arst_no_done", {31'd0, done}, 32'd0);
    launch(32'd2, 32'd340, 32'd1);
    for (int i = 0; i < V_SIZE; i++) tick();
    chk("arst_rerun_last", {31'd0, s_last}, 32'd1);
    chk("arst_rerun_data", s_data, 32'd24);
    tick();
    chk("arst_rerun_done", {31'd0, done}, 32'd1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
